// File: rtl/fft16_output_reorder.sv
// ============================================================================
// Module      : fft16_output_reorder
// Description : Ping-pong reorder buffer that turns 16-point FFT frames
//               arriving in bit-reversed bin order into a natural-order
//               valid/ready stream with start/end-of-frame markers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft16_output_reorder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] In_Re,
  input  logic [WIDTH-1:0] In_Im,
  input  logic             Out_Ready,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Out_Re,
  output logic [WIDTH-1:0] Out_Im,
  output logic             Out_Sof,
  output logic             Out_Eof,
  output logic             Drop,
  output logic             Overflow
);

  localparam logic [3:0] c_LAST_BIN = 4'd15;

  // Two banks of 16 entries; the bank bit is the MSB of the address.
  logic [2*WIDTH-1:0] r_mem [0:31];

  logic [1:0] r_full;
  logic [3:0] r_wr_cnt;
  logic       r_wr_bank;
  logic       r_wr_bad;
  logic [3:0] r_rd_cnt;
  logic       r_rd_bank;

  logic [4:0]         w_wr_addr;
  logic [4:0]         w_rd_addr;
  logic               w_store;
  logic               w_discard;
  logic               w_wr_last;
  logic               w_set;
  logic               w_load;
  logic               w_rd_last;
  logic               w_clr;
  logic [1:0]         w_full_nxt;
  logic [2*WIDTH-1:0] w_rd_data;

  assign w_wr_addr = {r_wr_bank, r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2], r_wr_cnt[3]};
  assign w_rd_addr = {r_rd_bank, r_rd_cnt};
  assign w_store   = In_Valid & ~r_full[r_wr_bank];
  assign w_discard = In_Valid &  r_full[r_wr_bank];
  assign w_wr_last = (r_wr_cnt == c_LAST_BIN);
  // A frame that lost any sample is never published to the reader.
  assign w_set     = w_store & w_wr_last & ~r_wr_bad;
  assign w_load    = r_full[r_rd_bank] & (~Out_Valid | Out_Ready);
  assign w_rd_last = (r_rd_cnt == c_LAST_BIN);
  assign w_clr     = w_load & w_rd_last;
  assign w_rd_data = r_mem[w_rd_addr];

  always_comb begin
    w_full_nxt = r_full;
    if (w_clr) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_set) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[w_wr_addr] <= {In_Re, In_Im};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_cnt  <= 4'd0;
      r_wr_bank <= 1'b0;
      r_wr_bad  <= 1'b0;
      Drop      <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      r_full   <= w_full_nxt;
      Drop     <= w_discard;
      Overflow <= Overflow | w_discard;
      if (In_Valid) begin
        r_wr_cnt <= r_wr_cnt + 4'd1;
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
          r_wr_bad  <= 1'b0;
        end else if (w_discard) begin
          r_wr_bad  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt  <= 4'd0;
      r_rd_bank <= 1'b0;
      Out_Valid <= 1'b0;
      Out_Re    <= '0;
      Out_Im    <= '0;
      Out_Sof   <= 1'b0;
      Out_Eof   <= 1'b0;
    end else if (w_load) begin
      r_rd_cnt  <= r_rd_cnt + 4'd1;
      if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      Out_Valid <= 1'b1;
      Out_Re    <= w_rd_data[2*WIDTH-1:WIDTH];
      Out_Im    <= w_rd_data[WIDTH-1:0];
      Out_Sof   <= (r_rd_cnt == 4'd0);
      Out_Eof   <= w_rd_last;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
      Out_Sof   <= 1'b0;
      Out_Eof   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft16_output_reorder.sv
// ============================================================================
// Module      : tb_fft16_output_reorder
// Description : Self-checking bench for fft16_output_reorder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fft16_output_reorder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         In_Valid = 1'b0;
  logic [W-1:0] In_Re = '0;
  logic [W-1:0] In_Im = '0;
  logic         Out_Ready = 1'b1;
  logic         Out_Valid;
  logic [W-1:0] Out_Re;
  logic [W-1:0] Out_Im;
  logic         Out_Sof;
  logic         Out_Eof;
  logic         Drop;
  logic         Overflow;

  fft16_output_reorder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .In_Valid  (In_Valid),
    .In_Re     (In_Re),
    .In_Im     (In_Im),
    .Out_Ready (Out_Ready),
    .Out_Valid (Out_Valid),
    .Out_Re    (Out_Re),
    .Out_Im    (Out_Im),
    .Out_Sof   (Out_Sof),
    .Out_Eof   (Out_Eof),
    .Drop      (Drop),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sof;
    logic         eof;
    int           cyc;
  } smp_t;

  smp_t got_q[$];
  smp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;
  int drop_cnt = 0;
  int last_in_cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int bitrev(input int n);
    return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
  endfunction

  // Collect accepted outputs, count drops, and check stalled outputs hold still.
  logic        held = 1'b0;
  logic [63:0] hold_val = '0;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held)
        chk("stall_hold", {29'd0, Out_Valid, Out_Re, Out_Im, Out_Sof, Out_Eof}, hold_val);
      if (Drop) drop_cnt++;
      if (Out_Valid && Out_Ready) begin
        smp_t s;
        s.re = Out_Re; s.im = Out_Im; s.sof = Out_Sof; s.eof = Out_Eof; s.cyc = cyc;
        got_q.push_back(s);
      end
      held     = Out_Valid && !Out_Ready;
      hold_val = {29'd0, Out_Valid, Out_Re, Out_Im, Out_Sof, Out_Eof};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       Out_Ready = ~Out_Ready;
      2:       Out_Ready = 1'b0;
      default: Out_Ready = 1'b1;
    endcase
  endtask

  // Drive nsamp samples of one frame; a kept full frame adds its natural-order image to exp_q.
  task automatic send_frame(input int max_gap, input bit ramp, input bit keep, input int nsamp);
    logic [W-1:0] re [16];
    logic [W-1:0] im [16];
    int gap;
    smp_t e;
    for (int k = 0; k < 16; k++) begin
      if (ramp) begin
        re[k] = W'(k);
        im[k] = W'(-k);
      end else begin
        re[k] = W'($urandom);
        im[k] = W'($urandom);
      end
    end
    for (int k = 0; k < nsamp; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        In_Valid = 1'b0;
        tick();
      end
      In_Valid = 1'b1;
      In_Re    = re[k];
      In_Im    = im[k];
      tick();
      last_in_cyc = cyc;
    end
    In_Valid = 1'b0;
    if (keep && nsamp == 16) begin
      for (int n = 0; n < 16; n++) begin
        e.re  = re[bitrev(n)];
        e.im  = im[bitrev(n)];
        e.sof = (n == 0);
        e.eof = (n == 15);
        e.cyc = 0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got_q.size() < n && t < 2000) begin
      tick();
      t++;
    end
    repeat (4) tick();
  endtask

  task automatic cmp_frames(input string tag);
    int n;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_smp"},
          {30'd0, got_q[i].re, got_q[i].im, got_q[i].sof, got_q[i].eof},
          {30'd0, exp_q[i].re, exp_q[i].im, exp_q[i].sof, exp_q[i].eof});
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
    drop_cnt = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(Out_Valid), 64'd0);
    chk({tag, "_re"},    64'(Out_Re),    64'd0);
    chk({tag, "_im"},    64'(Out_Im),    64'd0);
    chk({tag, "_sof"},   64'(Out_Sof),   64'd0);
    chk({tag, "_eof"},   64'(Out_Eof),   64'd0);
    chk({tag, "_drop"},  64'(Drop),      64'd0);
    chk({tag, "_ovf"},   64'(Overflow),  64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();

    // Single ramp frame, natural order and latency
    clear_q();
    send_frame(0, 1'b1, 1'b1, 16);
    wait_out(16);
    cmp_frames("single");
    if (got_q.size() > 0)
      chk("single_latency", 64'(got_q[0].cyc), 64'(last_in_cyc + 1));

    // Four back-to-back frames at full rate
    clear_q();
    repeat (4) send_frame(0, 1'b0, 1'b1, 16);
    wait_out(64);
    cmp_frames("b2b");
    if (got_q.size() == 64)
      chk("b2b_span", 64'(got_q[63].cyc - got_q[0].cyc), 64'd63);
    chk("b2b_drops", 64'(drop_cnt), 64'd0);
    chk("b2b_ovf",   64'(Overflow), 64'd0);

    // Backpressure with toggling ready
    clear_q();
    ready_mode = 1;
    send_frame(0, 1'b0, 1'b1, 16);
    wait_out(16);
    ready_mode = 0;
    tick();
    cmp_frames("bp");

    // Gapped input
    clear_q();
    send_frame(3, 1'b1, 1'b1, 16);
    wait_out(16);
    cmp_frames("gap");
    if (got_q.size() > 0)
      chk("gap_latency", 64'(got_q[0].cyc), 64'(last_in_cyc + 1));

    // Overflow: two frames buffered, the third fully dropped
    clear_q();
    ready_mode = 2;
    Out_Ready  = 1'b0;
    send_frame(0, 1'b0, 1'b1, 16);
    send_frame(0, 1'b0, 1'b1, 16);
    send_frame(0, 1'b0, 1'b0, 16);
    repeat (4) tick();
    chk("ovf_drops", 64'(drop_cnt), 64'd16);
    chk("ovf_flag",  64'(Overflow), 64'd1);
    chk("ovf_held",  64'(got_q.size()), 64'd0);
    ready_mode = 0;
    wait_out(32);
    cmp_frames("ovf_drain");
    chk("ovf_sticky", 64'(Overflow), 64'd1);

    // Reset after 7 input samples
    send_frame(0, 1'b0, 1'b0, 7);
    rst = 1'b1;
    tick();
    chk_reset_state("rst_mid_in");
    rst = 1'b0;
    clear_q();
    send_frame(0, 1'b1, 1'b1, 16);
    wait_out(16);
    cmp_frames("rst_mid_in_frame");

    // Reset while a frame is being emitted
    clear_q();
    send_frame(0, 1'b0, 1'b0, 16);
    for (int t = 0; t < 100 && got_q.size() < 5; t++) tick();
    chk("rst_mid_out_active", 64'(Out_Valid), 64'd1);
    rst = 1'b1;
    tick();
    chk_reset_state("rst_mid_out");
    rst = 1'b0;
    clear_q();
    repeat (3) tick();
    chk("rst_mid_out_quiet", 64'(got_q.size()), 64'd0);
    send_frame(0, 1'b0, 1'b1, 16);
    wait_out(16);
    cmp_frames("rst_mid_out_frame");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
